// File: rtl/cache_mem_ctrl_if.sv
// Cache-side and memory-side signal bundle of the cache memory controller.
// The slave modport is the controller's view; master is the surrounding system's.
interface cache_mem_ctrl_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
) ();
  logic                  miss_req;
  logic [ADDR_WIDTH-1:0] miss_addr;
  logic                  busy;
  logic                  refill_valid;
  logic [ADDR_WIDTH-1:0] refill_addr;
  logic [DATA_WIDTH-1:0] refill_data;
  logic                  wr_req;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  wr_ready;
  logic                  mem_req_valid;
  logic                  mem_req_ready;
  logic                  mem_req_we;
  logic [ADDR_WIDTH-1:0] mem_req_addr;
  logic [DATA_WIDTH-1:0] mem_req_wdata;
  logic                  mem_resp_valid;
  logic [DATA_WIDTH-1:0] mem_resp_data;

  modport slave (
    input  miss_req, miss_addr, wr_req, wr_addr, wr_data,
    input  mem_req_ready, mem_resp_valid, mem_resp_data,
    output busy, refill_valid, refill_addr, refill_data, wr_ready,
    output mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata
  );

  modport master (
    output miss_req, miss_addr, wr_req, wr_addr, wr_data,
    output mem_req_ready, mem_resp_valid, mem_resp_data,
    input  busy, refill_valid, refill_addr, refill_data, wr_ready,
    input  mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata
  );
endinterface

// File: rtl/cache_mem_ctrl.sv
// Memory-side controller for a write-through cache: posted write buffer drained ahead of
// single-word miss reads, with the fetched word returned as a one-cycle refill strobe.
module cache_mem_ctrl #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned WB_DEPTH   = 4
) (
  input logic              clk,
  input logic              rst,
  cache_mem_ctrl_if.slave  bus
);
  localparam int unsigned PtrW = $clog2(WB_DEPTH);
  localparam logic [PtrW:0] DepthC = (PtrW + 1)'(WB_DEPTH);

  typedef enum logic [2:0] {StIdle, StWrReq, StRdReq, StRdWait, StRefill} state_e;

  state_e                state_q, state_d;
  logic [PtrW:0]         cnt_q, cnt_d;
  logic [PtrW-1:0]       wptr_q, wptr_d, rptr_q, rptr_d;
  logic [ADDR_WIDTH-1:0] wb_addr_q [WB_DEPTH];
  logic [DATA_WIDTH-1:0] wb_data_q [WB_DEPTH];
  logic                  miss_pend_q, miss_pend_d;
  logic [ADDR_WIDTH-1:0] refill_addr_q, refill_addr_d;
  logic [DATA_WIDTH-1:0] refill_data_q, refill_data_d;

  logic                  wr_ready, push, pop, miss_acc, miss_any;
  logic                  mem_req_valid, mem_req_we, refill_valid;
  logic [ADDR_WIDTH-1:0] mem_req_addr;
  logic [DATA_WIDTH-1:0] mem_req_wdata;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    wptr_d        = wptr_q;
    rptr_d        = rptr_q;
    miss_pend_d   = miss_pend_q;
    refill_addr_d = refill_addr_q;
    refill_data_d = refill_data_q;
    mem_req_valid = 1'b0;
    mem_req_we    = 1'b0;
    mem_req_addr  = '0;
    mem_req_wdata = '0;
    refill_valid  = 1'b0;

    // Registered state only: a pop this cycle cannot open a slot this cycle.
    wr_ready = (cnt_q < DepthC) && !miss_pend_q;
    push     = bus.wr_req && wr_ready;
    miss_acc = bus.miss_req && !miss_pend_q;
    miss_any = miss_pend_q || miss_acc;
    pop      = (state_q == StWrReq) && bus.mem_req_ready;

    if (push) wptr_d = wptr_q + 1'b1;
    if (pop)  rptr_d = rptr_q + 1'b1;
    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase

    if (miss_acc) begin
      miss_pend_d   = 1'b1;
      refill_addr_d = bus.miss_addr;
    end

    unique case (state_q)
      StIdle: begin
        // A store accepted alongside the miss must still reach memory before the read.
        if (miss_any) begin
          state_d = (cnt_q != '0 || push) ? StWrReq : StRdReq;
        end else if (cnt_q != '0) begin
          state_d = StWrReq;
        end
      end
      StWrReq: begin
        mem_req_valid = 1'b1;
        mem_req_we    = 1'b1;
        mem_req_addr  = wb_addr_q[rptr_q];
        mem_req_wdata = wb_data_q[rptr_q];
        if (pop) begin
          if (cnt_d != '0)   state_d = StWrReq;
          else if (miss_any) state_d = StRdReq;
          else               state_d = StIdle;
        end
      end
      StRdReq: begin
        mem_req_valid = 1'b1;
        mem_req_addr  = refill_addr_q;
        if (bus.mem_req_ready) state_d = StRdWait;
      end
      StRdWait: begin
        if (bus.mem_resp_valid) begin
          refill_data_d = bus.mem_resp_data;
          state_d       = StRefill;
        end
      end
      StRefill: begin
        refill_valid = 1'b1;
        miss_pend_d  = 1'b0;
        state_d      = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StIdle;
      cnt_q         <= '0;
      wptr_q        <= '0;
      rptr_q        <= '0;
      miss_pend_q   <= 1'b0;
      refill_addr_q <= '0;
      refill_data_q <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      wptr_q        <= wptr_d;
      rptr_q        <= rptr_d;
      miss_pend_q   <= miss_pend_d;
      refill_addr_q <= refill_addr_d;
      refill_data_q <= refill_data_d;
    end
  end

  // Buffer storage needs no reset; the count alone decides what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      wb_addr_q[wptr_q] <= bus.wr_addr;
      wb_data_q[wptr_q] <= bus.wr_data;
    end
  end

  assign bus.busy          = miss_pend_q;
  assign bus.refill_valid  = refill_valid;
  assign bus.refill_addr   = refill_addr_q;
  assign bus.refill_data   = refill_data_q;
  assign bus.wr_ready      = wr_ready;
  assign bus.mem_req_valid = mem_req_valid;
  assign bus.mem_req_we    = mem_req_we;
  assign bus.mem_req_addr  = mem_req_addr;
  assign bus.mem_req_wdata = mem_req_wdata;
endmodule

// File: tb/tb_cache_mem_ctrl.sv
// Bench for cache_mem_ctrl: cycle vector table, a request-stall sequence, and random
// traffic checked against a write-queue / memory-image reference model.
module tb_cache_mem_ctrl;
  localparam int WB = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cache_mem_ctrl_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

  cache_mem_ctrl #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .WB_DEPTH(WB)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    bit rst; bit miss; logic [31:0] maddr; bit wr; logic [31:0] waddr; logic [31:0] wdata;
    bit rdy; bit rvi; logic [31:0] rdi;
    bit full; bit busy; bit wrdy; bit mv; bit we; logic [31:0] addr; logic [31:0] wd;
    bit rv; logic [31:0] ra; logic [31:0] rd;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(
    bit rst, bit miss, logic [31:0] maddr, bit wr, logic [31:0] waddr, logic [31:0] wdata,
    bit rdy, bit rvi, logic [31:0] rdi,
    bit full, bit busy, bit wrdy, bit mv, bit we, logic [31:0] addr, logic [31:0] wd,
    bit rv, logic [31:0] ra, logic [31:0] rd);
    vec_t v;
    v.rst = rst; v.miss = miss; v.maddr = maddr; v.wr = wr; v.waddr = waddr; v.wdata = wdata;
    v.rdy = rdy; v.rvi = rvi; v.rdi = rdi;
    v.full = full; v.busy = busy; v.wrdy = wrdy; v.mv = mv; v.we = we; v.addr = addr;
    v.wd = wd; v.rv = rv; v.ra = ra; v.rd = rd;
    return v;
  endfunction

  // Reference model state for the random phase.
  typedef struct { logic [31:0] a; logic [31:0] d; } wr_t;
  wr_t         wq[$];
  logic [31:0] ref_mem [logic [31:0]];
  logic [31:0] sim_mem [logic [31:0]];
  bit          miss_out, rd_out, hold_prev, prev_we;
  int          rd_delay;
  logic [31:0] exp_raddr, exp_rdata, rd_val, prev_addr, prev_wd;

  function automatic logic [31:0] init_val(logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  function automatic logic [31:0] ref_rd(logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_val(a);
  endfunction

  function automatic logic [31:0] sim_rd(logic [31:0] a);
    return sim_mem.exists(a) ? sim_mem[a] : init_val(a);
  endfunction

  function automatic logic [31:0] rand_addr();
    return 32'h100 + (32'($urandom_range(0, 7)) << 2);
  endfunction

  task automatic drive_idle();
    bus.miss_req = 1'b0; bus.miss_addr = '0; bus.wr_req = 1'b0; bus.wr_addr = '0;
    bus.wr_data = '0; bus.mem_req_ready = 1'b0; bus.mem_resp_valid = 1'b0;
    bus.mem_resp_data = '0;
  endtask

  task automatic rand_cycle(input bit gen);
    bit wacc, macc, hs, rsp, saw_rv, rd_was;
    @(negedge clk);
    chk("rnd.busy", bus.busy, miss_out);
    chk("rnd.wr_ready", bus.wr_ready, (wq.size() < WB) && !miss_out);
    if (hold_prev) begin
      chk("rnd.hold_valid", bus.mem_req_valid, 1);
      chk("rnd.hold_we", bus.mem_req_we, prev_we);
      chk("rnd.hold_addr", bus.mem_req_addr, prev_addr);
      if (prev_we) chk("rnd.hold_wdata", bus.mem_req_wdata, prev_wd);
    end
    saw_rv = bus.refill_valid;
    if (saw_rv) begin
      chk("rnd.refill_pending", miss_out, 1);
      chk("rnd.refill_addr", bus.refill_addr, exp_raddr);
      chk("rnd.refill_data", bus.refill_data, exp_rdata);
    end
    bus.miss_req      = gen && ($urandom_range(0, 5) == 0);
    bus.miss_addr     = rand_addr();
    bus.wr_req        = gen && ($urandom_range(0, 1) == 0);
    bus.wr_addr       = rand_addr();
    bus.wr_data       = $urandom;
    bus.mem_req_ready = ($urandom_range(0, 3) != 0);
    rd_was = rd_out;
    rsp    = rd_out && (rd_delay == 0);
    if (rsp) begin
      bus.mem_resp_valid = 1'b1;
      bus.mem_resp_data  = rd_val;
    end else begin
      // Stray responses only while no read is outstanding; they must be ignored.
      bus.mem_resp_valid = !rd_out && ($urandom_range(0, 7) == 0);
      bus.mem_resp_data  = $urandom;
    end
    #1;
    wacc = bus.wr_req && bus.wr_ready;
    macc = bus.miss_req && !bus.busy;
    hs   = bus.mem_req_valid && bus.mem_req_ready;
    if (hs && bus.mem_req_we) begin
      n_cmp++;
      if (wq.size() == 0) begin
        n_fail++;
        $display("FAIL rnd.spurious_write: got addr %h, expected no write", bus.mem_req_addr);
      end else begin
        chk("rnd.wr_addr", bus.mem_req_addr, wq[0].a);
        chk("rnd.wr_data", bus.mem_req_wdata, wq[0].d);
        void'(wq.pop_front());
      end
      sim_mem[bus.mem_req_addr] = bus.mem_req_wdata;
    end else if (hs) begin
      chk("rnd.rd_after_writes", wq.size(), 0);
      chk("rnd.rd_addr", bus.mem_req_addr, exp_raddr);
      chk("rnd.rd_single", rd_out, 0);
      rd_out   = 1'b1;
      rd_delay = $urandom_range(0, 3);
      rd_val   = sim_rd(bus.mem_req_addr);
    end
    hold_prev = bus.mem_req_valid && !bus.mem_req_ready;
    prev_we   = bus.mem_req_we;
    prev_addr = bus.mem_req_addr;
    prev_wd   = bus.mem_req_wdata;
    @(posedge clk);
    if (rsp) rd_out = 1'b0;
    else if (rd_was) rd_delay--;
    if (saw_rv) miss_out = 1'b0;
    if (wacc) begin
      wq.push_back('{a: bus.wr_addr, d: bus.wr_data});
      ref_mem[bus.wr_addr] = bus.wr_data;
    end
    if (macc) begin
      miss_out  = 1'b1;
      exp_raddr = bus.miss_addr;
      exp_rdata = ref_rd(bus.miss_addr);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    int guard;
    int n_hs, n_rv;
    vec_t v;

    // Single miss after reset: accept t, read handshake t+1, resp t+2, refill t+3.
    vecs.push_back(mk(0,1,'h40,0,0,0,1,0,0,            1,0,1,0,0,0,0,0,0,0));
    vecs.push_back(mk(0,0,0,0,0,0,1,0,0,               0,1,0,1,0,'h40,0,0,0,0));
    vecs.push_back(mk(0,0,0,0,0,0,1,1,'hDEADBEEF,      0,1,0,0,0,0,0,0,0,0));
    vecs.push_back(mk(0,0,0,0,0,0,1,0,0,               0,1,0,0,0,0,0,1,'h40,'hDEADBEEF));
    vecs.push_back(mk(0,0,0,0,0,0,1,0,0,               0,0,1,0,0,0,0,0,0,0));
    // Four back-to-back stores with memory stalled, then drained in order.
    vecs.push_back(mk(0,0,0,1,'h100,1,0,0,0,           0,0,1,0,0,0,0,0,0,0));
    vecs.push_back(mk(0,0,0,1,'h104,2,0,0,0,           0,0,1,0,0,0,0,0,0,0));
    vecs.push_back(mk(0,0,0,1,'h108,3,0,0,0,           0,0,1,1,1,'h100,1,0,0,0));
    vecs.push_back(mk(0,0,0,1,'h10C,4,0,0,0,           0,0,1,1,1,'h100,1,0,0,0));
    vecs.push_back(mk(0,0,0,0,0,0,1,0,0,               0,0,0,1,1,'h100,1,0,0,0));
    vecs.push_back(mk(0,0,0,0,0,0,1,0,0,               0,0,1,1,1,'h104,2,0,0,0));
    vecs.push_back(mk(0,0,0,0,0,0,1,0,0,               0,0,1,1,1,'h108,3,0,0,0));
    vecs.push_back(mk(0,0,0,0,0,0,1,0,0,               0,0,1,1,1,'h10C,4,0,0,0));
    vecs.push_back(mk(0,0,0,0,0,0,1,0,0,               0,0,1,0,0,0,0,0,0,0));
    // Same-cycle miss and store: store goes out first, then the read.
    vecs.push_back(mk(0,1,'h200,1,'h200,'hA5A5A5A5,1,0,0, 0,0,1,0,0,0,0,0,0,0));
    vecs.push_back(mk(0,0,0,0,0,0,1,0,0,               0,1,0,1,1,'h200,'hA5A5A5A5,0,0,0));
    vecs.push_back(mk(0,0,0,0,0,0,1,0,0,               0,1,0,1,0,'h200,0,0,0,0));
    vecs.push_back(mk(0,0,0,0,0,0,1,1,'hA5A5A5A5,      0,1,0,0,0,0,0,0,0,0));
    vecs.push_back(mk(0,0,0,0,0,0,1,0,0,               0,1,0,0,0,0,0,1,'h200,'hA5A5A5A5));
    vecs.push_back(mk(0,0,0,0,0,0,1,0,0,               0,0,1,0,0,0,0,0,0,0));
    // Reset while waiting for read data; the late response must be ignored.
    vecs.push_back(mk(0,1,'h300,0,0,0,1,0,0,           0,0,1,0,0,0,0,0,0,0));
    vecs.push_back(mk(0,0,0,0,0,0,1,0,0,               0,1,0,1,0,'h300,0,0,0,0));
    vecs.push_back(mk(1,0,0,0,0,0,1,0,0,               0,1,0,0,0,0,0,0,0,0));
    vecs.push_back(mk(0,0,0,0,0,0,1,1,'h1234,          1,0,1,0,0,0,0,0,0,0));
    vecs.push_back(mk(0,0,0,0,0,0,1,0,0,               0,0,1,0,0,0,0,0,0,0));
    vecs.push_back(mk(0,0,0,0,0,0,1,0,0,               0,0,1,0,0,0,0,0,0,0));

    drive_idle();
    repeat (3) @(posedge clk);

    foreach (vecs[i]) begin
      v = vecs[i];
      @(negedge clk);
      rst = v.rst;
      bus.miss_req = v.miss; bus.miss_addr = v.maddr;
      bus.wr_req = v.wr; bus.wr_addr = v.waddr; bus.wr_data = v.wdata;
      bus.mem_req_ready = v.rdy; bus.mem_resp_valid = v.rvi; bus.mem_resp_data = v.rdi;
      #1;
      chk($sformatf("vec%0d.busy", i), bus.busy, v.busy);
      chk($sformatf("vec%0d.wr_ready", i), bus.wr_ready, v.wrdy);
      chk($sformatf("vec%0d.mem_req_valid", i), bus.mem_req_valid, v.mv);
      chk($sformatf("vec%0d.refill_valid", i), bus.refill_valid, v.rv);
      if (v.mv || v.full) begin
        chk($sformatf("vec%0d.mem_req_we", i), bus.mem_req_we, v.we);
        chk($sformatf("vec%0d.mem_req_addr", i), bus.mem_req_addr, v.addr);
      end
      if ((v.mv && v.we) || v.full)
        chk($sformatf("vec%0d.mem_req_wdata", i), bus.mem_req_wdata, v.wd);
      if (v.rv || v.full) begin
        chk($sformatf("vec%0d.refill_addr", i), bus.refill_addr, v.ra);
        chk($sformatf("vec%0d.refill_data", i), bus.refill_data, v.rd);
      end
    end

    // Read request stalled five cycles: request held steady, one handshake, one refill.
    @(negedge clk);
    drive_idle();
    bus.miss_req = 1'b1; bus.miss_addr = 32'h44;
    @(negedge clk);
    bus.miss_req = 1'b0;
    n_hs = 0;
    n_rv = 0;
    for (int c = 0; c < 5; c++) begin
      #1;
      chk($sformatf("stall%0d.valid", c), bus.mem_req_valid, 1);
      chk($sformatf("stall%0d.we", c), bus.mem_req_we, 0);
      chk($sformatf("stall%0d.addr", c), bus.mem_req_addr, 32'h44);
      @(negedge clk);
    end
    bus.mem_req_ready = 1'b1;
    #1;
    if (bus.mem_req_valid) n_hs++;
    @(negedge clk);
    bus.mem_resp_valid = 1'b1; bus.mem_resp_data = 32'hCAFE_F00D;
    #1;
    if (bus.mem_req_valid) n_hs++;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      bus.mem_resp_valid = 1'b0;
      #1;
      if (bus.mem_req_valid) n_hs++;
      if (bus.refill_valid) begin
        n_rv++;
        chk("stall.refill_addr", bus.refill_addr, 32'h44);
        chk("stall.refill_data", bus.refill_data, 32'hCAFE_F00D);
      end
    end
    chk("stall.handshakes", n_hs, 1);
    chk("stall.refills", n_rv, 1);
    chk("stall.busy_after", bus.busy, 0);

    // Random traffic against the reference model, then a bounded drain.
    drive_idle();
    miss_out = 1'b0; rd_out = 1'b0; hold_prev = 1'b0; rd_delay = 0;
    for (int c = 0; c < 3000; c++) rand_cycle(1'b1);
    guard = 0;
    while ((wq.size() != 0 || miss_out || rd_out) && guard < 300) begin
      rand_cycle(1'b0);
      guard++;
    end
    chk("rnd.drain_done", (wq.size() == 0) && !miss_out && !rd_out, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/cache_mem_ctrl.md
# cache_mem_ctrl

Memory-side controller directly downstream of the direct-mapped write-through data cache. It takes the cache's read-miss requests and write-through stores, drains stores through a small posted write buffer, and fetches miss words from main memory over a valid/ready request channel. Miss data is returned to the cache as a single-cycle refill strobe. Pending writes always reach memory before any later miss read is issued.

## Interface
- ADDR_WIDTH, 32, byte address width
- DATA_WIDTH, 32, word width
- WB_DEPTH, 4, write-buffer entries (power of 2, ≥2)

- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- miss_req  in  1  cache read miss; accepted when busy=0
- miss_addr  in  ADDR_WIDTH  miss address, sampled on acceptance
- busy  out  1  cache must stall; miss in progress
- refill_valid  out  1  one-cycle strobe, refill_addr/refill_data valid
- refill_addr  out  ADDR_WIDTH  latched miss address
- refill_data  out  DATA_WIDTH  word returned by memory
- wr_req  in  1  write-through store; accepted when wr_ready=1
- wr_addr  in  ADDR_WIDTH  store address
- wr_data  in  DATA_WIDTH  store data
- wr_ready  out  1  write buffer can accept
- mem_req_valid  out  1  memory request valid
- mem_req_ready  in  1  memory accepts request
- mem_req_we  out  1  1 = write (posted, no response), 0 = read
- mem_req_addr  out  ADDR_WIDTH  request address
- mem_req_wdata  out  DATA_WIDTH  write data (don't-care on reads)
- mem_resp_valid  in  1  read data valid
- mem_resp_data  in  DATA_WIDTH  read data

## Operation
- Write buffer: FIFO of WB_DEPTH {addr,data}, registered count, wrapping pointers. Push on wr_req && wr_ready. Pop on a write handshake. Push and pop in the same cycle are allowed; count is unchanged.
- wr_ready = (count < WB_DEPTH) && !busy. It is computed from registered state only, so a same-cycle pop never raises it.
- A miss is accepted on miss_req && !busy. It latches miss_addr into refill_addr and sets busy the next cycle.
- A wr_req in the same cycle as miss acceptance is also accepted and enqueued.
- States:
  - IDLE
    - miss pending && count>0 → WR_REQ
    - miss pending && count==0 → RD_REQ
    - no miss && count>0 → WR_REQ
    - otherwise stay
  - WR_REQ: mem_req_valid=1, we=1, head addr/data. On mem_req_ready: pop, then
    - count-after-pop>0 → stay
    - else miss pending → RD_REQ
    - else → IDLE
    - A miss accepted while in WR_REQ does not abort the drain.
  - RD_REQ: mem_req_valid=1, we=0, addr=refill_addr. On mem_req_ready → RD_WAIT.
  - RD_WAIT: on mem_resp_valid, register mem_resp_data into refill_data → REFILL.
  - REFILL: refill_valid=1 for exactly one cycle; clear miss pending → IDLE.
- busy=1 from the cycle after acceptance through the REFILL cycle inclusive; 0 the next cycle.
- mem_req_valid, we, addr and wdata are held stable until handshake; valid never drops without ready.
- mem_resp_valid outside RD_WAIT is ignored.
- Only one read is outstanding at any time.

## Timing
- Reset values:
  - Outputs: busy, refill_valid, mem_req_valid, mem_req_we all 0; refill_addr, refill_data, mem_req_addr, mem_req_wdata all 0; wr_ready 1 (empty buffer, not busy).
  - Internal: FIFO empty, state IDLE.
- rst mid-transaction: return to IDLE next cycle; buffered writes and any pending miss are discarded.
- Miss latency, empty buffer, ready=1, response one cycle after the request handshake:
  - accept at t
  - RD_REQ handshake at t+1
  - resp at t+2
  - refill_valid at t+3
  - busy low at t+4
- Each buffered write adds one cycle ahead of RD_REQ when ready=1. Stalls on mem_req_ready add cycles 1:1.
- Write from empty buffer: push at t, WR_REQ valid at t+2 (state IDLE at t+1 sees count=1).

## Test plan
- Reset, then single miss to 0x0000_0040, mem returns 0xDEADBEEF one cycle after handshake → refill_valid exactly at t+3 with addr 0x40, data 0xDEADBEEF; busy high t+1..t+3.
- Push 4 writes (0x100..0x10C, data 1..4) back to back → wr_ready=0 after the 4th; memory sees 4 we=1 requests in order; wr_ready returns 1 the cycle after count<4.
- 2 writes buffered then miss to 0x104 → both writes handshake before the read request; refill carries memory's post-write value.
- mem_req_ready held 0 for 5 cycles in RD_REQ → valid/addr stable all 5 cycles; a single handshake; one refill.
- Same-cycle miss_req and wr_req (0x200, 0xA5A5A5A5) → write issued first, then read; wr_ready=0 until after REFILL.
- rst asserted in RD_WAIT with 2 writes queued → next cycle all outputs at reset values; a late mem_resp_valid produces no refill_valid.
